// File: rtl/simple_bus_master.sv
// simple_bus_master: single-outstanding initiator for the simple_bus memory
// interface. A command (valid/ready) becomes one bus strobe; reads wait for
// outp_valid or a timeout. Exactly one response (valid/ready) is returned per command.
// Optional build macro SBM_WRITE_VERIFY_EN: every write is followed by an
// automatic read-back of the same address. The response flags an error if
// the read-back data differs from the written data or the read times out.
module simple_bus_master #(
    parameter int AW      = 3,
    parameter int DW      = 4,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_wr,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err,
    output logic          wr,
    output logic          rd,
    output logic [AW-1:0] addr,
    output logic [DW-1:0] wdata,
    input  logic [DW-1:0] rdata,
    input  logic          outp_valid
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STROBE = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    // Last WAIT cycle index; the counter starts at 0 in the first WAIT cycle.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t        state_r, state_s;
    logic          wr_r, wr_s;
    logic          rd_r, rd_s;
    logic [AW-1:0] addr_r, addr_s;
    logic [DW-1:0] wdata_r, wdata_s;
    logic          lat_wr_r, lat_wr_s;
    logic          rsp_valid_r, rsp_valid_s;
    logic [DW-1:0] rsp_rdata_r, rsp_rdata_s;
    logic          rsp_err_r, rsp_err_s;
    logic [7:0]    cnt_r, cnt_s;
`ifdef SBM_WRITE_VERIFY_EN
    logic          verify_r, verify_s;
`endif

    assign cmd_ready = (state_r == ST_IDLE);
    assign wr        = wr_r;
    assign rd        = rd_r;
    assign addr      = addr_r;
    assign wdata     = wdata_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;

    // Next-state and next-output logic; strobes default low so they last one cycle.
    always_comb begin
        state_s     = state_r;
        wr_s        = 1'b0;
        rd_s        = 1'b0;
        addr_s      = addr_r;
        wdata_s     = wdata_r;
        lat_wr_s    = lat_wr_r;
        rsp_valid_s = rsp_valid_r;
        rsp_rdata_s = rsp_rdata_r;
        rsp_err_s   = rsp_err_r;
        cnt_s       = cnt_r;
`ifdef SBM_WRITE_VERIFY_EN
        verify_s    = verify_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_s  = ST_STROBE;
                    wr_s     = cmd_wr;
                    rd_s     = ~cmd_wr;
                    addr_s   = cmd_addr;
                    wdata_s  = cmd_wdata;
                    lat_wr_s = cmd_wr;
`ifdef SBM_WRITE_VERIFY_EN
                    verify_s = 1'b0;
`endif
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_STROBE: begin
                if (lat_wr_r) begin
`ifdef SBM_WRITE_VERIFY_EN
                    // Re-enter STROBE as a read of the same address.
                    state_s  = ST_STROBE;
                    rd_s     = 1'b1;
                    lat_wr_s = 1'b0;
                    verify_s = 1'b1;
`else
                    state_s     = ST_RESP;
                    rsp_valid_s = 1'b1;
                    rsp_rdata_s = {DW{1'b0}};
                    rsp_err_s   = 1'b0;
`endif
                end else begin
                    state_s = ST_WAIT;
                    cnt_s   = 8'd0;
                end
            end
            ST_WAIT: begin
                // outp_valid takes priority over a coincident timeout.
                if (outp_valid) begin
                    state_s     = ST_RESP;
                    rsp_valid_s = 1'b1;
                    rsp_rdata_s = rdata;
`ifdef SBM_WRITE_VERIFY_EN
                    rsp_err_s   = verify_r & (rdata != wdata_r);
`else
                    rsp_err_s   = 1'b0;
`endif
                end else if (cnt_r == TO_LAST) begin
                    state_s     = ST_RESP;
                    rsp_valid_s = 1'b1;
                    rsp_rdata_s = {DW{1'b0}};
                    rsp_err_s   = 1'b1;
                end else begin
                    cnt_s = cnt_r + 8'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_s     = ST_IDLE;
                    rsp_valid_s = 1'b0;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: begin
                state_s     = ST_IDLE;
                rsp_valid_s = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset aborts any command in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            wr_r        <= 1'b0;
            rd_r        <= 1'b0;
            addr_r      <= {AW{1'b0}};
            wdata_r     <= {DW{1'b0}};
            lat_wr_r    <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= {DW{1'b0}};
            rsp_err_r   <= 1'b0;
            cnt_r       <= 8'd0;
`ifdef SBM_WRITE_VERIFY_EN
            verify_r    <= 1'b0;
`endif
        end else begin
            state_r     <= state_s;
            wr_r        <= wr_s;
            rd_r        <= rd_s;
            addr_r      <= addr_s;
            wdata_r     <= wdata_s;
            lat_wr_r    <= lat_wr_s;
            rsp_valid_r <= rsp_valid_s;
            rsp_rdata_r <= rsp_rdata_s;
            rsp_err_r   <= rsp_err_s;
            cnt_r       <= cnt_s;
`ifdef SBM_WRITE_VERIFY_EN
            verify_r    <= verify_s;
`endif
        end
    end

endmodule
